// File: rtl/gio_pkg.sv
// Shared constants and per-bit register bundle for the GIO input conditioner.
package gio_pkg;

    localparam int GIO_WIDTH           = 8;
    localparam int DEBOUNCE_10MS_50MHZ = 500000;
    localparam int DEBOUNCE_SIM        = 4;
    localparam int GIO_CNT_W           = 24;

    // Everything one conditioned pin keeps between edges, except its counter.
    typedef struct packed {
        logic s1;
        logic s2;
        logic level;
        logic rise;
        logic fall;
        logic latched;
    } gio_bit_state_t;

endpackage : gio_pkg

// File: rtl/gio_input_conditioner_if.sv
// Pin-level bundle between the board switches, the conditioner and the CPU GIO port.
interface gio_input_conditioner_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] raw_pins;
    logic [WIDTH-1:0] clr_latch;
    logic [WIDTH-1:0] gio_pins;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [WIDTH-1:0] press_latched;

    modport master (
        output raw_pins,
        output clr_latch,
        input  gio_pins,
        input  rise_pulse,
        input  fall_pulse,
        input  press_latched
    );

    modport slave (
        input  raw_pins,
        input  clr_latch,
        output gio_pins,
        output rise_pulse,
        output fall_pulse,
        output press_latched
    );
endinterface : gio_input_conditioner_if

// File: rtl/gio_debounce_bit.sv
// One conditioned pin: two-flop synchroniser, stability counter, debounced level,
// registered edge pulses and a sticky press latch cleared by software.
module gio_debounce_bit
    import gio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter int CNT_W           = GIO_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    input  logic clr_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic latched_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    gio_bit_state_t   st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: default every comb output first so no path leaves a latch behind.
        st_d  = st_q;
        cnt_d = cnt_q;

        st_d.s1 = raw_i;
        st_d.s2 = st_q.s1;

        // Any sample agreeing with the current level restarts the stability count.
        if (st_q.s2 == st_q.level) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            st_d.level = st_q.s2;
            cnt_d      = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        st_d.rise    = st_d.level & ~st_q.level;
        st_d.fall    = ~st_d.level & st_q.level;
        // A rise on the same edge as a clear wins, so no press is lost.
        st_d.latched = st_d.rise | (st_q.latched & ~clr_i);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q  <= '0;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    assign level_o   = st_q.level;
    assign rise_o    = st_q.rise;
    assign fall_o    = st_q.fall;
    assign latched_o = st_q.latched;

endmodule : gio_debounce_bit

// File: rtl/gio_input_conditioner.sv
// Conditions the raw board switches feeding the CPU GIO_pins port, one
// independent debounce slice per pin.
module gio_input_conditioner
    import gio_pkg::*;
#(
    parameter int WIDTH           = GIO_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter int CNT_W           = GIO_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    gio_input_conditioner_if.slave  bus
);

    logic [WIDTH-1:0] level_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] latched_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk       (clk),
            .reset     (reset),
            .raw_i     (bus.raw_pins[i]),
            .clr_i     (bus.clr_latch[i]),
            .level_o   (level_w[i]),
            .rise_o    (rise_w[i]),
            .fall_o    (fall_w[i]),
            .latched_o (latched_w[i])
        );
    end

    assign bus.gio_pins      = level_w;
    assign bus.rise_pulse    = rise_w;
    assign bus.fall_pulse    = fall_w;
    assign bus.press_latched = latched_w;

endmodule : gio_input_conditioner
